branch_predictor: RTL

- Fetch-side direction predictor and branch target buffer (BTB).
- Produces the fetch-stage `prediction` bit and the predicted target consumed by PC-select logic.
- Carries the prediction down the F→D→E pipeline so it arrives as `predictionE` for execute-stage branch resolution.
- Takes the resolved outcome back from execute to train 2-bit saturating counters and BTB entries, and keeps branch and mispredict statistics.

---
 rtl/branch_predictor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Fetch-side direction predictor (2-bit saturating counters) plus branch
//   target buffer. The fetch lookup is purely combinational; the prediction
//   bit travels F->D->E so execute can detect a mispredict. Execute-stage
//   outcomes train the tables and update branch/mispredict statistics.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   PCF          fetch-stage PC
//   StallD       hold the F->D prediction register
//   FlushD       clear the F->D prediction register (wins over StallD)
//   FlushE       clear the D->E prediction register
//   BranchE      a conditional branch resolves in execute this cycle
//   BtakenE      resolved direction of that branch
//   PCE          PC of the execute-stage branch
//   PCTargetE    resolved target of the execute-stage branch
//   prediction   fetch-stage predicted-taken (combinational)
//   PCPredF      predicted next PC: BTB target when predicted taken, else PCF+4
//   predictionE  prediction bit aligned with execute
//   mispredictE  BranchE & (predictionE != BtakenE)
//   branch_cnt   resolved branch count (wraps)
//   mispred_cnt  mispredicted branch count (wraps)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic        BranchE,
    input  logic        BtakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic        prediction,
    output logic [31:0] PCPredF,
    output logic        predictionE,
    output logic        mispredictE,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : (c + 2'b01);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : (c - 2'b01);
    endfunction

    logic [1:0]       cnt_r    [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [TAG_W-1:0] tag_r    [DEPTH];
    logic [31:0]      target_r [DEPTH];

    logic             prediction_d_r;
    logic             prediction_e_r;
    logic [31:0]      branch_cnt_r;
    logic [31:0]      mispred_cnt_r;

    logic [IDX_W-1:0] idx_f_s;
    logic [IDX_W-1:0] idx_e_s;
    logic             hit_s;
    logic             prediction_s;
    logic [31:0]      pc_pred_s;
    logic             mispredict_s;
    logic             unused_s;

    assign idx_f_s  = PCF[IDX_W+1:2];
    assign idx_e_s  = PCE[IDX_W+1:2];
    // Word-aligned PCs: the two low bits never participate in lookup.
    assign unused_s = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup: reads the table state as it stood before this edge, so a
    // same-index update only becomes visible the following cycle.
    always_comb begin
        hit_s        = valid_r[idx_f_s] && (tag_r[idx_f_s] == PCF[31:IDX_W+2]);
        prediction_s = hit_s && cnt_r[idx_f_s][1];
        if (prediction_s) begin
            pc_pred_s = target_r[idx_f_s];
        end else begin
            pc_pred_s = PCF + 32'd4;
        end
        mispredict_s = BranchE && (prediction_e_r != BtakenE);
    end

    // Direction counters and valid bits; reset overrides a concurrent update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_r[i] <= CNT_INIT;
            end
            valid_r <= '0;
        end else if (BranchE) begin
            if (BtakenE) begin
                cnt_r[idx_e_s]   <= sat_inc(cnt_r[idx_e_s]);
                valid_r[idx_e_s] <= 1'b1;
            end else begin
                // Not-taken leaves the BTB entry alone; a stale valid entry
                // stops predicting once the counter drops below 10.
                cnt_r[idx_e_s] <= sat_dec(cnt_r[idx_e_s]);
            end
        end
    end

    // BTB tag/target payload; no reset needed because valid gates every use.
    always_ff @(posedge clk) begin
        if (BranchE && BtakenE) begin
            tag_r[idx_e_s]    <= PCE[31:IDX_W+2];
            target_r[idx_e_s] <= PCTargetE;
        end
    end

    // Prediction pipeline F->D->E; flush takes priority over stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prediction_d_r <= 1'b0;
            prediction_e_r <= 1'b0;
        end else begin
            if (FlushD) begin
                prediction_d_r <= 1'b0;
            end else if (!StallD) begin
                prediction_d_r <= prediction_s;
            end
            prediction_e_r <= FlushE ? 1'b0 : prediction_d_r;
        end
    end

    // Branch and mispredict statistics, wrapping modulo 2**32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (BranchE) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
            if (mispredict_s) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign prediction  = prediction_s;
    assign PCPredF     = pc_pred_s;
    assign predictionE = prediction_e_r;
    assign mispredictE = mispredict_s;
    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule
